// File: rtl/usb_pd_encode.sv
// USB PD transmit PHY: preamble, ordered set, 4b5b payload,
// CRC32 and EOP, BMC-coded onto the CC line.
module usb_pd_encode #(
  parameter int UI_CLKS       = 90,
  parameter int HALF_CLKS     = 45,
  parameter int HOLD_CLKS     = 27,
  parameter int PREAMBLE_BITS = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] sop_sel,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       cc_out,
  output logic       cc_oe,
  output logic       busy,
  output logic       done,
  output logic       tx_err
);

  typedef enum logic [2:0] {
    IDLE, PREAMBLE, ORDSET, PAYLOAD, CRC, EOP, TAIL
  } state_t;

  localparam int CW = $clog2(UI_CLKS);
  localparam int BW = $clog2(PREAMBLE_BITS);
  localparam logic [CW-1:0] UI_END   = CW'(UI_CLKS - 1);
  localparam logic [CW-1:0] HALF_AT  = CW'(HALF_CLKS - 1);
  localparam logic [CW-1:0] HOLD_END = CW'(HOLD_CLKS - 1);
  localparam logic [BW-1:0] PRE_END  = BW'(PREAMBLE_BITS - 1);
  localparam logic [BW-1:0] SYM_END  = BW'(4);

  localparam logic [4:0] S1 = 5'b11000;
  localparam logic [4:0] S2 = 5'b10001;
  localparam logic [4:0] S3 = 5'b00110;
  localparam logic [4:0] R1 = 5'b00111;
  localparam logic [4:0] R2 = 5'b11001;
  localparam logic [4:0] SYM_EOP = 5'b01101;

  function automatic logic [4:0] enc4(input logic [3:0] n);
    logic [4:0] s;
    case (n)
      4'h0: s = 5'b11110;
      4'h1: s = 5'b01001;
      4'h2: s = 5'b10100;
      4'h3: s = 5'b10101;
      4'h4: s = 5'b01010;
      4'h5: s = 5'b01011;
      4'h6: s = 5'b01110;
      4'h7: s = 5'b01111;
      4'h8: s = 5'b10010;
      4'h9: s = 5'b10011;
      4'hA: s = 5'b10110;
      4'hB: s = 5'b10111;
      4'hC: s = 5'b11010;
      4'hD: s = 5'b11011;
      4'hE: s = 5'b11100;
      default: s = 5'b11101;
    endcase
    return s;
  endfunction

  function automatic logic [4:0] ord_sym(
    input logic [1:0] s,
    input logic [1:0] i
  );
    logic [4:0] r;
    case (s)
      2'd0:    r = (i == 2'd3) ? S2 : S1;
      2'd1:    r = i[1] ? S3 : S1;
      2'd2:    r = i[0] ? S3 : S1;
      default: r = (i == 2'd3) ? R2 : R1;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] crc_byte(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  state_t          state, state_d;
  logic [CW-1:0]   cnt;
  logic [BW-1:0]   bit_n;
  logic [2:0]      sym_n, sym_n_d;
  logic [4:0]      sym, sym_d;
  logic [1:0]      sel;
  logic            hr, nib, nib_d;
  logic            buf_full, last_taken, tail_hi;
  logic [7:0]      buf_data;
  logic [31:0]     crc, crc_out;
  logic [3:0]      crc_nib;
  logic            in_cell, cell_end, cur_bit, last_bit;
  logic            sym_end, tail_end, hs;
  logic            pay_ld, buf_free, err_d;

  assign crc_out  = ~crc;
  assign busy     = (state != IDLE);
  assign tx_ready = (state == PREAMBLE || state == ORDSET ||
                     state == PAYLOAD) &&
                    !buf_full && !last_taken && !hr;
  assign hs       = tx_valid && tx_ready;
  assign in_cell  = (state == PREAMBLE) || (state == ORDSET) ||
                    (state == PAYLOAD)  || (state == CRC) ||
                    (state == EOP);
  assign cell_end = in_cell && (cnt == UI_END);
  assign cur_bit  = (state == PREAMBLE) ? bit_n[0] : sym[0];
  assign last_bit = (state == PREAMBLE) ? (bit_n == PRE_END)
                                        : (bit_n == SYM_END);
  assign sym_end  = cell_end && last_bit;
  assign tail_end = (state == TAIL) && !tail_hi &&
                    (cnt == HOLD_END);

  always_comb begin
    state_d  = state;
    sym_d    = sym;
    sym_n_d  = sym_n;
    nib_d    = nib;
    buf_free = 1'b0;
    err_d    = 1'b0;
    pay_ld   = 1'b0;
    crc_nib  = 4'd0;
    if (state == IDLE && start) state_d = PREAMBLE;
    if (tail_end) state_d = IDLE;
    if (cell_end && !last_bit) sym_d = sym >> 1;
    if (sym_end) begin
      unique case (state)
        PREAMBLE: begin
          state_d = ORDSET;
          sym_n_d = 3'd0;
          sym_d   = ord_sym(sel, 2'd0);
        end
        ORDSET: begin
          if (sym_n != 3'd3) begin
            sym_n_d = sym_n + 3'd1;
            sym_d   = ord_sym(sel, sym_n_d[1:0]);
          end else if (hr) begin
            state_d = TAIL;
          end else begin
            pay_ld = 1'b1;
          end
        end
        PAYLOAD: pay_ld = 1'b1;
        CRC: begin
          if (sym_n != 3'd7) begin
            sym_n_d = sym_n + 3'd1;
            crc_nib = 4'(crc_out >> {sym_n_d, 2'b00});
            sym_d   = enc4(crc_nib);
          end else begin
            state_d = EOP;
            sym_d   = SYM_EOP;
          end
        end
        EOP: state_d = TAIL;
        default: ;
      endcase
    end
    // Low nibble first; an empty buffer before tx_last is an underrun
    if (pay_ld) begin
      unique case (1'b1)
        nib: begin
          state_d  = PAYLOAD;
          sym_d    = enc4(buf_data[7:4]);
          nib_d    = 1'b0;
          buf_free = 1'b1;
        end
        !nib && buf_full: begin
          state_d = PAYLOAD;
          sym_d   = enc4(buf_data[3:0]);
          nib_d   = 1'b1;
        end
        !nib && !buf_full && last_taken: begin
          state_d = CRC;
          sym_n_d = 3'd0;
          sym_d   = enc4(crc_out[3:0]);
        end
        !nib && !buf_full && !last_taken: begin
          state_d = EOP;
          sym_d   = SYM_EOP;
          err_d   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_n      <= '0;
      sym_n      <= '0;
      sym        <= '0;
      sel        <= '0;
      hr         <= 1'b0;
      nib        <= 1'b0;
      buf_full   <= 1'b0;
      buf_data   <= '0;
      last_taken <= 1'b0;
      tail_hi    <= 1'b0;
      crc        <= '1;
      cc_out     <= 1'b0;
      cc_oe      <= 1'b0;
      done       <= 1'b0;
      tx_err     <= 1'b0;
    end else begin
      state  <= state_d;
      sym    <= sym_d;
      sym_n  <= sym_n_d;
      nib    <= nib_d;
      done   <= tail_end;
      tx_err <= err_d;
      if (hs) begin
        buf_full <= 1'b1;
        buf_data <= tx_data;
        crc      <= crc_byte(crc, tx_data);
        if (tx_last) last_taken <= 1'b1;
      end else if (buf_free) begin
        buf_full <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            sel    <= sop_sel;
            hr     <= &sop_sel;
            cc_oe  <= 1'b1;
            cc_out <= 1'b1;
            cnt    <= '0;
            bit_n  <= '0;
          end
        end
        TAIL: begin
          if (tail_hi) begin
            if (cnt == HALF_AT) begin
              cc_out  <= 1'b0;
              tail_hi <= 1'b0;
              cnt     <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end else if (cnt == HOLD_END) begin
            cc_oe      <= 1'b0;
            crc        <= '1;
            buf_full   <= 1'b0;
            last_taken <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          if (cnt == UI_END) begin
            cnt    <= '0;
            cc_out <= ~cc_out;
            bit_n  <= last_bit ? '0 : bit_n + BW'(1);
            // A low line first goes high for half a UI
            if (state_d == TAIL) tail_hi <= ~cc_out;
          end else begin
            cnt <= cnt + CW'(1);
            if (cnt == HALF_AT && cur_bit) cc_out <= ~cc_out;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_pd_encode.sv
// Bench for usb_pd_encode: packets built from the bit-level rules,
// compared cycle by cycle and decoded back to bytes and CRC.
module tb_usb_pd_encode;
  localparam int UI = 90;
  localparam int HALF = 45;
  localparam int HOLD = 27;
  localparam logic [4:0] S1 = 5'b11000;
  localparam logic [4:0] S2 = 5'b10001;
  localparam logic [4:0] S3 = 5'b00110;
  localparam logic [4:0] R1 = 5'b00111;
  localparam logic [4:0] R2 = 5'b11001;
  localparam logic [4:0] EOPS = 5'b01101;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [1:0] sop_sel = 2'd0;
  logic [7:0] tx_data = 8'd0;
  logic tx_valid = 1'b0;
  logic tx_last = 1'b0;
  logic tx_ready, cc_out, cc_oe, busy, done, tx_err;

  int checks = 0;
  int failures = 0;

  bit         eb[$];
  bit         ew[$];
  bit         db[$];
  logic [3:0] sw[$];
  logic [7:0] pay[$];
  logic [31:0] mcrc;
  logic [31:0] dcrc;

  usb_pd_encode dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sop_sel(sop_sel),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
    .tx_ready(tx_ready), .cc_out(cc_out), .cc_oe(cc_oe),
    .busy(busy), .done(done), .tx_err(tx_err)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] enc(input logic [3:0] n);
    case (n)
      4'h0: return 5'b11110;  4'h1: return 5'b01001;
      4'h2: return 5'b10100;  4'h3: return 5'b10101;
      4'h4: return 5'b01010;  4'h5: return 5'b01011;
      4'h6: return 5'b01110;  4'h7: return 5'b01111;
      4'h8: return 5'b10010;  4'h9: return 5'b10011;
      4'hA: return 5'b10110;  4'hB: return 5'b10111;
      4'hC: return 5'b11010;  4'hD: return 5'b11011;
      4'hE: return 5'b11100;  default: return 5'b11101;
    endcase
  endfunction

  function automatic int dec(input logic [4:0] s);
    for (int i = 0; i < 16; i++)
      if (enc(4'(i)) == s) return i;
    return 16;
  endfunction

  function automatic void push_sym(input logic [4:0] s);
    for (int i = 0; i < 5; i++) eb.push_back(s[i]);
  endfunction

  function automatic logic [4:0] get_sym(input int p);
    logic [4:0] s;
    for (int i = 0; i < 5; i++) s[i] = db[p+i];
    return s;
  endfunction

  task automatic build(input logic [1:0] sel, input bit ur);
    logic [31:0] c;
    logic [4:0] os[4];
    bit lvl;
    eb.delete();
    ew.delete();
    for (int i = 0; i < 64; i++) eb.push_back(i % 2 == 1);
    case (sel)
      2'd0: os = '{S1, S1, S1, S2};
      2'd1: os = '{S1, S1, S3, S3};
      2'd2: os = '{S1, S3, S1, S3};
      default: os = '{R1, R1, R1, R2};
    endcase
    for (int i = 0; i < 4; i++) push_sym(os[i]);
    c = 32'hFFFFFFFF;
    if (sel != 2'd3) begin
      foreach (pay[i]) begin
        push_sym(enc(pay[i][3:0]));
        push_sym(enc(pay[i][7:4]));
        for (int b = 0; b < 8; b++) begin
          bit fb;
          fb = c[0] ^ pay[i][b];
          c = c >> 1;
          if (fb) c = c ^ 32'hEDB88320;
        end
      end
      mcrc = ~c;
      if (!ur)
        for (int n = 0; n < 8; n++) push_sym(enc(mcrc[4*n +: 4]));
      push_sym(EOPS);
    end
    lvl = 1'b0;
    foreach (eb[j]) begin
      lvl = ~lvl;
      for (int t = 0; t < UI; t++) begin
        if (t == HALF && eb[j]) lvl = ~lvl;
        ew.push_back(lvl);
      end
    end
    if (!lvl) for (int t = 0; t < HALF; t++) ew.push_back(1'b1);
    for (int t = 0; t < HOLD; t++) ew.push_back(1'b0);
  endtask

  task automatic run(input string tag, input logic [1:0] sel,
                     input bit ur, input bit poke);
    int n, nb, p, mis, first, bmis;
    int err_cnt, err_k, rdy_cnt, rdy_after, lo, hi;
    logic [3:0] fgot, fwant, e;
    build(sel, ur);
    n = ew.size();
    nb = eb.size();
    sw.delete();
    err_cnt = 0; err_k = -1; rdy_cnt = 0; rdy_after = 0;
    @(negedge clk);
    sop_sel = sel;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    fork
      begin
        for (int k = 0; k <= n + 1; k++) begin
          sw.push_back({cc_oe, cc_out, busy, done});
          if (tx_ready) rdy_cnt++;
          if (tx_ready && err_cnt > 0) rdy_after++;
          if (tx_err) begin err_cnt++; err_k = k; end
          if (poke && (k == 1000 || k == n - 1)) start = 1'b1;
          if (poke && (k == 1001 || k == n)) start = 1'b0;
          @(negedge clk);
        end
      end
      begin
        if (sel != 2'd3)
          for (int i = 0; i < pay.size(); i++) begin
            int w;
            w = 0;
            tx_data = pay[i];
            tx_valid = 1'b1;
            tx_last = !ur && (i == pay.size() - 1);
            while (!tx_ready && w < 20000) begin
              @(negedge clk);
              w++;
            end
            if (w >= 20000) begin
              checks++;
              failures++;
              $error("FAIL %s_feed timeout byte=%0d", tag, i);
            end
            @(negedge clk);
            tx_valid = 1'b0;
            tx_last = 1'b0;
            repeat ($urandom_range(0, 60)) @(negedge clk);
          end
      end
    join
    mis = 0; first = -1; fgot = 4'd0; fwant = 4'd0;
    for (int k = 0; k <= n + 1; k++) begin
      if (k < n) e = {1'b1, ew[k], 1'b1, 1'b0};
      else if (k == n) e = 4'b0001;
      else e = 4'b0000;
      if (sw[k] !== e) begin
        mis++;
        if (first < 0) begin first = k; fgot = sw[k]; fwant = e; end
      end
    end
    checks++;
    assert (mis === 0) else begin
      failures++;
      $error("FAIL %s_wave bad=%0d k=%0d got=%b exp=%b",
             tag, mis, first, fgot, fwant);
    end
    checks++;
    assert (err_cnt === (ur ? 1 : 0)) else begin
      failures++;
      $error("FAIL %s_err_cnt got=%0d exp=%0d", tag, err_cnt, ur);
    end
    checks++;
    assert (err_k === (ur ? (84 + 10 * pay.size()) * UI : -1)) else begin
      failures++;
      $error("FAIL %s_err_time got=%0d", tag, err_k);
    end
    if (sel == 2'd3) begin
      checks++;
      assert (rdy_cnt === 0) else begin
        failures++;
        $error("FAIL %s_ready got=%0d exp=0", tag, rdy_cnt);
      end
    end
    if (ur) begin
      checks++;
      assert (rdy_after === 0) else begin
        failures++;
        $error("FAIL %s_ready_after got=%0d exp=0", tag, rdy_after);
      end
    end
    if (sel != 2'd3) begin
      db.delete();
      for (int c = 0; c < nb; c++)
        db.push_back(sw[c*UI][2] ^ sw[c*UI+HALF][2]);
      p = 84;
      bmis = 0;
      foreach (pay[i]) begin
        lo = dec(get_sym(p));
        hi = dec(get_sym(p + 5));
        p += 10;
        if (lo > 15 || hi > 15 || (hi * 16 + lo) != int'(pay[i]))
          bmis++;
      end
      checks++;
      assert (bmis === 0) else begin
        failures++;
        $error("FAIL %s_bytes bad=%0d exp=0", tag, bmis);
      end
      if (!ur) begin
        dcrc = '0;
        for (int k = 0; k < 8; k++) begin
          lo = dec(get_sym(p));
          p += 5;
          dcrc[4*k +: 4] = 4'(lo);
        end
        checks++;
        assert (dcrc === mcrc) else begin
          failures++;
          $error("FAIL %s_crc got=%h exp=%h", tag, dcrc, mcrc);
        end
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    checks++;
    assert ({cc_oe, cc_out, busy, done, tx_err, tx_ready} === 6'd0)
    else begin
      failures++;
      $error("FAIL reset_state got=%b exp=000000",
             {cc_oe, cc_out, busy, done, tx_err, tx_ready});
    end
    rst_n = 1'b1;

    pay.delete();
    for (int i = 0; i < 9; i++) pay.push_back(8'h31 + 8'(i));
    run("ascii", 2'd0, 1'b0, 1'b1);
    checks++;
    assert (dcrc === 32'hCBF43926) else begin
      failures++;
      $error("FAIL ascii_crc_const got=%h exp=cbf43926", dcrc);
    end

    pay.delete();
    run("hardreset", 2'd3, 1'b0, 1'b1);

    pay.delete();
    pay.push_back(8'h11);
    pay.push_back(8'h13);
    run("underrun", 2'd1, 1'b1, 1'b0);

    @(negedge clk);
    sop_sel = 2'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tx_data = 8'hA5;
    tx_valid = 1'b1;
    tx_last = 1'b0;
    repeat (8300) @(negedge clk);
    checks++;
    assert ({busy, cc_oe} === 2'b11) else begin
      failures++;
      $error("FAIL pre_reset_busy got=%b exp=11", {busy, cc_oe});
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    assert ({cc_oe, cc_out, busy, done, tx_ready} === 5'd0) else begin
      failures++;
      $error("FAIL mid_reset got=%b exp=00000",
             {cc_oe, cc_out, busy, done, tx_ready});
    end
    tx_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    pay.delete();
    for (int i = 0; i < int'($urandom_range(1, 3)); i++)
      pay.push_back(8'($urandom));
    run("after_reset", 2'd0, 1'b0, 1'b0);

    pay.delete();
    for (int i = 0; i < int'($urandom_range(1, 3)); i++)
      pay.push_back(8'($urandom));
    run("random", 2'($urandom_range(0, 2)), 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
